dispense_unit: RTL and testbench



---
 rtl/dispense_unit.sv | 134 +++++++++++++
 tb/tb_dispense_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dispense_unit.sv
// Slot dispenser: runs the slot motor for MOTOR_CYCLES, waits up to TIMEOUT for a drop, then done/reject/jam.
// Requests are taken only in IDLE with no queueing; done/reject are one-cycle pulses, jam holds until jam_clr.
module dispense_unit #(
   parameter int MOTOR_CYCLES = 4,
   parameter int TIMEOUT      = 16,
   parameter int STOCK_W      = 4,
   parameter int STOCK_INIT   = 3,
   parameter int STOCK_MAX    = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [1:0] slot,
   input  logic       drop_sensor,
   input  logic       restock,
   input  logic [1:0] restock_slot,
   input  logic       jam_clr,
   output logic       motor_en,
   output logic [1:0] motor_sel,
   output logic       busy,
   output logic       done,
   output logic       reject,
   output logic       jam,
   output logic [3:0] empty,
   output logic [2:0] state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RUN    = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_REJECT = 3'd4;
   localparam logic [2:0] S_JAM    = 3'd5;

   // One counter serves both the motor run and the drop timeout.
   localparam int CNT_MAX = (MOTOR_CYCLES > TIMEOUT) ? MOTOR_CYCLES : TIMEOUT;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]   RUN_LOAD  = CNT_W'(MOTOR_CYCLES - 1);
   localparam logic [CNT_W-1:0]   WAIT_LOAD = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [STOCK_W-1:0] ST_INIT   = STOCK_W'(STOCK_INIT);
   localparam logic [STOCK_W-1:0] ST_MAX    = STOCK_W'(STOCK_MAX);
   localparam logic [STOCK_W-1:0] ST_ONE    = STOCK_W'(1);

   logic [2:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         sel_q, sel_d;
   logic               drop_seen_q, drop_seen_d;
   logic [STOCK_W-1:0] stock_q [4];
   logic [STOCK_W-1:0] stock_d [4];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sel_q       <= 2'd0;
         drop_seen_q <= 1'b0;
         for (int i = 0; i < 4; i++) stock_q[i] <= ST_INIT;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         drop_seen_q <= drop_seen_d;
         for (int i = 0; i < 4; i++) stock_q[i] <= stock_d[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      drop_seen_d = drop_seen_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               sel_d       = slot;
               drop_seen_d = 1'b0;
               if (stock_q[slot] == '0) begin
                  state_d = S_REJECT;
               end else begin
                  state_d = S_RUN;
                  cnt_d   = RUN_LOAD;
               end
            end
         end
         S_RUN: begin
            if (drop_sensor) drop_seen_d = 1'b1;
            if (cnt_q == '0) begin
               // A drop on the last motor cycle still counts as a drop during RUN.
               if (drop_seen_q || drop_sensor) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_WAIT: begin
            if (drop_sensor)         state_d = S_DONE;
            else if (cnt_q == '0)    state_d = S_JAM;
            else                     cnt_d   = cnt_q - CNT_ONE;
         end
         S_DONE:   state_d = S_IDLE;
         S_REJECT: state_d = S_IDLE;
         S_JAM:    if (jam_clr) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Restock is applied last so it overrides a same-cycle DONE decrement.
   always_comb begin
      for (int i = 0; i < 4; i++) stock_d[i] = stock_q[i];
      if (state_q == S_DONE && stock_q[sel_q] != '0)
         stock_d[sel_q] = stock_q[sel_q] - ST_ONE;
      if (restock)
         stock_d[restock_slot] = ST_MAX;
   end

   always_comb begin
      motor_en = (state_q == S_RUN);
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_DONE);
      reject   = (state_q == S_REJECT);
      jam      = (state_q == S_JAM);
      for (int i = 0; i < 4; i++) empty[i] = (stock_q[i] == '0);
   end

   assign motor_sel = sel_q;
   assign state     = state_q;

endmodule

// File: tb/tb_dispense_unit.sv
// Scoreboarded bench for dispense_unit: stimulus queues expected done/reject/jam events, a monitor pops them.
module tb_dispense_unit;

   logic       clk = 1'b0;
   logic       rst, req, drop_sensor, restock, jam_clr;
   logic [1:0] slot, restock_slot;
   logic       motor_en, busy, done, reject, jam;
   logic [1:0] motor_sel;
   logic [3:0] empty;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int kind;   // 1 = done, 2 = reject, 3 = jam
      int sel;
   } evt_t;
   evt_t exp_q [$];

   dispense_unit dut (
      .clk(clk), .rst(rst), .req(req), .slot(slot), .drop_sensor(drop_sensor),
      .restock(restock), .restock_slot(restock_slot), .jam_clr(jam_clr),
      .motor_en(motor_en), .motor_sel(motor_sel), .busy(busy), .done(done),
      .reject(reject), .jam(jam), .empty(empty), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every done/reject pulse and every jam rising edge must match the queue head.
   initial begin
      logic jam_prev;
      int   code;
      evt_t e;
      jam_prev = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || reject === 1'b1 || (jam === 1'b1 && !jam_prev)) begin
            code = (done === 1'b1) ? 1 : (reject === 1'b1) ? 2 : 3;
            if (exp_q.size() == 0) begin
               check("unexpected_event", code, 0);
            end else begin
               e = exp_q.pop_front();
               check("event_kind", code, e.kind);
               check("event_sel", {30'd0, motor_sel}, e.sel);
            end
         end
         jam_prev = (jam === 1'b1);
      end
   end

   // Issue one request and follow it until IDLE or JAM, counting what each cycle shows.
   task automatic vend(input string name, input logic [1:0] s, input int drop_k, input int rs_k,
                       input int exp_evt, input int exp_run, input int exp_wait,
                       input int exp_done, input int exp_len, input int exp_fin);
      int nrun, nwait, ndone, nlen, selbad;
      logic [2:0] fin;
      evt_t e;
      nrun = 0; nwait = 0; ndone = 0; nlen = -1; selbad = 0; fin = 3'd7;
      e.kind = exp_evt;
      e.sel  = s;
      exp_q.push_back(e);
      req = 1'b1; slot = s;
      tick();
      req = 1'b0;
      for (int k = 0; k < 40; k++) begin
         fin = state;
         if (state == 3'd0 || state == 3'd5) begin
            nlen = k;
            break;
         end
         if (motor_en) nrun++;
         if (state == 3'd2) nwait++;
         if (state == 3'd3) ndone++;
         if (motor_sel != s) selbad++;
         drop_sensor  = (k == drop_k);
         restock      = (k == rs_k);
         restock_slot = s;
         tick();
      end
      drop_sensor = 1'b0;
      restock     = 1'b0;
      check({name, "_motor_cycles"}, nrun, exp_run);
      check({name, "_wait_cycles"}, nwait, exp_wait);
      check({name, "_done_cycles"}, ndone, exp_done);
      check({name, "_length"}, nlen, exp_len);
      check({name, "_final_state"}, {29'd0, fin}, exp_fin);
      check({name, "_motor_sel"}, selbad, 0);
   endtask

   task automatic do_restock(input logic [1:0] s);
      restock = 1'b1; restock_slot = s;
      tick();
      restock = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req = 1'b0; slot = 2'd0; drop_sensor = 1'b0;
      restock = 1'b0; restock_slot = 2'd0; jam_clr = 1'b0;
      tick();
      rst = 1'b0;
      check("reset_state", {29'd0, state}, 0);
      check("reset_motor_en", {31'd0, motor_en}, 0);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_done", {31'd0, done}, 0);
      check("reset_jam", {31'd0, jam}, 0);
      check("reset_motor_sel", {30'd0, motor_sel}, 0);
      check("reset_empty", {28'd0, empty}, 4'b0000);

      // Slot 1: drop in RUN, drop in WAIT_DROP, then a third vend empties it.
      vend("run_drop",  2'd1, 1, -1, 1, 4, 0, 1, 5, 0);
      vend("wait_drop", 2'd1, 8, -1, 1, 4, 5, 1, 10, 0);
      check("empty_after_wait_drop", {28'd0, empty}, 4'b0000);
      vend("slot1_last", 2'd1, 0, -1, 1, 4, 0, 1, 5, 0);
      check("empty_slot1_out", {28'd0, empty}, 4'b0010);

      for (int i = 0; i < 3; i++) vend("slot2", 2'd2, 3, -1, 1, 4, 0, 1, 5, 0);
      check("empty_slot2_out", {28'd0, empty}, 4'b0110);
      do_restock(2'd1);
      check("empty_after_restock1", {28'd0, empty}, 4'b0100);

      // Jam on slot 3, requests ignored while jammed, operator clear.
      vend("jam", 2'd3, 99, -1, 3, 4, 16, 0, 20, 5);
      req = 1'b1; slot = 2'd0;
      tick();
      tick();
      req = 1'b0;
      check("jam_req_ignored_state", {29'd0, state}, 5);
      check("jam_req_ignored_motor", {31'd0, motor_en}, 0);
      check("jam_held", {31'd0, jam}, 1);
      check("jam_stock_unchanged", {28'd0, empty}, 4'b0100);
      jam_clr = 1'b1;
      tick();
      jam_clr = 1'b0;
      check("jam_clr_state", {29'd0, state}, 0);
      check("jam_clr_jam", {31'd0, jam}, 0);

      // Empty slot 0, reject, restock, vend again.
      for (int i = 0; i < 3; i++) vend("slot0", 2'd0, 0, -1, 1, 4, 0, 1, 5, 0);
      check("empty_slot0_out", {28'd0, empty}, 4'b0101);
      begin
         evt_t e;
         e.kind = 2; e.sel = 0;
         exp_q.push_back(e);
      end
      req = 1'b1; slot = 2'd0;
      tick();
      req = 1'b0;
      check("reject_state", {29'd0, state}, 4);
      check("reject_busy", {31'd0, busy}, 1);
      check("reject_motor", {31'd0, motor_en}, 0);
      tick();
      check("reject_back_idle", {29'd0, state}, 0);
      check("reject_busy_low", {31'd0, busy}, 0);
      check("reject_stock_unchanged", {28'd0, empty}, 4'b0101);
      do_restock(2'd0);
      check("empty_after_restock0", {28'd0, empty}, 4'b0100);
      vend("slot0_after_restock", 2'd0, 2, -1, 1, 4, 0, 1, 5, 0);

      // Restock on the DONE cycle of slot 3 must win: 15, then two vends leave 13.
      vend("collide", 2'd3, 0, 4, 1, 4, 0, 1, 5, 0);
      vend("post_collide_a", 2'd3, 1, -1, 1, 4, 0, 1, 5, 0);
      vend("post_collide_b", 2'd3, 1, -1, 1, 4, 0, 1, 5, 0);
      check("empty_after_collide", {28'd0, empty}, 4'b0100);

      // Reset in the middle of RUN: motor stops, no done, stock back to init.
      req = 1'b1; slot = 2'd3; drop_sensor = 1'b1;
      tick();
      req = 1'b0;
      check("midrun_motor_on", {31'd0, motor_en}, 1);
      tick();
      drop_sensor = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrun_rst_motor", {31'd0, motor_en}, 0);
      check("midrun_rst_state", {29'd0, state}, 0);
      check("midrun_rst_done", {31'd0, done}, 0);
      check("midrun_rst_empty", {28'd0, empty}, 4'b0000);
      repeat (6) tick();
      check("midrun_no_done_later", {31'd0, done}, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
